// File: rtl/median3x3_pipe_pkg.sv
// Shared constants for the 3x3 median filter pipeline.
//   SORT_LAT   : cycles through one registered 3-input sort stage
//   MEDIAN_LAT : column-in to median-out latency of median3x3_pipe
//   HI/MD/LO   : slot index of each field inside a packed {hi,md,lo} column bus
//   fill_t     : window fill counter type (0..3, saturating)
package median3x3_pipe_pkg;

    localparam int SORT_LAT   = 1;
    localparam int MEDIAN_LAT = 3;

    // Field slots of a sorted column; bit offset of a field is slot * DW.
    localparam int LO = 0;
    localparam int MD = 1;
    localparam int HI = 2;

    typedef logic [1:0] fill_t;
    localparam fill_t FILL_EMPTY = 2'd0;
    localparam fill_t FILL_ONE   = 2'd1;
    localparam fill_t FILL_FULL  = 2'd3;

endpackage : median3x3_pipe_pkg

// File: rtl/median3x3_pipe_sort3_stage.sv
// sort3_stage: registered 3-input unsigned sort.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : input qualifier; data registers load only when set
//   a, b, c    : DW-bit unsigned inputs
//   valid      : en delayed by one cycle
//   hi, md, lo : registered max / median / min of the last qualified inputs
// Data outputs hold their value while en is low, so downstream consumers see
// a stable value between valid strobes.
module sort3_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    output logic          valid,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] md,
    output logic [DW-1:0] lo
);

    logic [DW-1:0] hi_ab;
    logic [DW-1:0] lo_ab;
    logic [DW-1:0] hi_nxt;
    logic [DW-1:0] md_nxt;
    logic [DW-1:0] lo_nxt;

    // Three-comparator network: order a/b, then place c against each end.
    // Ties resolve by value only, so equal inputs give equal outputs.
    always_comb begin
        hi_ab  = (a >= b) ? a : b;
        lo_ab  = (a >= b) ? b : a;
        hi_nxt = (hi_ab >= c) ? hi_ab : c;
        lo_nxt = (lo_ab <= c) ? lo_ab : c;
        md_nxt = (hi_ab <= c) ? hi_ab : ((lo_ab >= c) ? lo_ab : c);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is asserted asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            hi    <= '0;
            md    <= '0;
            lo    <= '0;
        end else begin
            valid <= en;
            if (en) begin
                hi <= hi_nxt;
                md <= md_nxt;
                lo <= lo_nxt;
            end
        end
    end

endmodule : sort3_stage

// File: rtl/median3x3_pipe.sv
// median3x3_pipe: pipelined 3x3 median filter core.
//   clk, rst_n : clock, asynchronous active-low reset
//   valid_i    : column qualifier (no backpressure)
//   sol_i      : start of line, qualified by valid_i
//   d0_i..d2_i : top/mid/bottom pixel of the incoming column
//   valid_o    : median_o valid, 3 cycles after the completing column
//   median_o   : median of the 3x3 window (holds while valid_o is low)
//   max_o/min_o: window max/min, present only with MEDIAN_MINMAX_OUT_EN defined
// Parameters: DW pixel width; EDGE_REP=1 replicates the first column of a line
// into the whole window so output starts from the first column.
// Pipeline: S1 sorts the column, S2 updates the window and reduces it to
// lo_max / md_med / hi_min, S3 takes the median of those three.
import median3x3_pipe_pkg::*;

module median3x3_pipe #(
    parameter int DW       = 8,
    parameter int EDGE_REP = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic          sol_i,
    input  logic [DW-1:0] d0_i,
    input  logic [DW-1:0] d1_i,
    input  logic [DW-1:0] d2_i,
    output logic          valid_o,
    output logic [DW-1:0] median_o
`ifdef MEDIAN_MINMAX_OUT_EN
    ,
    output logic [DW-1:0] max_o,
    output logic [DW-1:0] min_o
`endif
);

    typedef logic [3*DW-1:0] col_t;

    function automatic logic [DW-1:0] fld(input col_t col, input int slot);
        return col[slot*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] max3(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] m;
        m = (a >= b) ? a : b;
        return (m >= c) ? m : c;
    endfunction

    function automatic logic [DW-1:0] min3(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] m;
        m = (a <= b) ? a : b;
        return (m <= c) ? m : c;
    endfunction

    function automatic logic [DW-1:0] med3(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] lo_ab;
        logic [DW-1:0] hi_ab;
        lo_ab = (a <= b) ? a : b;
        hi_ab = (a >= b) ? a : b;
        hi_ab = (hi_ab <= c) ? hi_ab : c;
        return (lo_ab >= hi_ab) ? lo_ab : hi_ab;
    endfunction

    // ---------------------------------------------------------------- S1
    logic          s1_valid;
    logic          s1_sol;
    logic [DW-1:0] s1_hi;
    logic [DW-1:0] s1_md;
    logic [DW-1:0] s1_lo;
    col_t          s1_col;

    sort3_stage #(.DW(DW)) u_col_sort (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (valid_i),
        .a     (d0_i),
        .b     (d1_i),
        .c     (d2_i),
        .valid (s1_valid),
        .hi    (s1_hi),
        .md    (s1_md),
        .lo    (s1_lo)
    );

    assign s1_col = {s1_hi, s1_md, s1_lo};

    // sol_i without valid_i is meaningless and must not restart the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s1_sol <= 1'b0;
        else        s1_sol <= sol_i & valid_i;
    end

    // ---------------------------------------------------------------- S2
    // Window slot 0 is the newest column. S2 reduces the *next* window so
    // the window update and the reduction share one cycle (latency 3).
    col_t  win      [3];
    col_t  win_next [3];
    fill_t fill;
    fill_t fill_next;
    logic  s2_load;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        win_next  = win;
        fill_next = fill;
        if (s1_valid) begin
            if (s1_sol && (EDGE_REP != 0)) begin
                win_next[0] = s1_col;
                win_next[1] = s1_col;
                win_next[2] = s1_col;
                fill_next   = FILL_FULL;
            end else begin
                win_next[0] = s1_col;
                win_next[1] = win[0];
                win_next[2] = win[1];
                if (s1_sol)                 fill_next = FILL_ONE;
                else if (fill != FILL_FULL) fill_next = fill + 2'd1;
            end
        end
    end

    assign s2_load = s1_valid && (fill_next == FILL_FULL);

    logic          s2_valid;
    logic [DW-1:0] s2_lo_max;
    logic [DW-1:0] s2_md_med;
    logic [DW-1:0] s2_hi_min;

    // NOTE: the window is a small register file, not a RAM, and a reset
    // mid-line must discard it, so its slots are reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) win[i] <= '0;
            fill      <= FILL_EMPTY;
            s2_valid  <= 1'b0;
            s2_lo_max <= '0;
            s2_md_med <= '0;
            s2_hi_min <= '0;
        end else begin
            for (int i = 0; i < 3; i++) win[i] <= win_next[i];
            fill     <= fill_next;
            s2_valid <= s2_load;
            if (s2_load) begin
                s2_lo_max <= max3(fld(win_next[0], LO), fld(win_next[1], LO), fld(win_next[2], LO));
                s2_md_med <= med3(fld(win_next[0], MD), fld(win_next[1], MD), fld(win_next[2], MD));
                s2_hi_min <= min3(fld(win_next[0], HI), fld(win_next[1], HI), fld(win_next[2], HI));
            end
        end
    end

    // ---------------------------------------------------------------- S3
    logic [DW-1:0] s3_hi_unused;
    logic [DW-1:0] s3_lo_unused;

    sort3_stage #(.DW(DW)) u_med_sort (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (s2_valid),
        .a     (s2_lo_max),
        .b     (s2_md_med),
        .c     (s2_hi_min),
        .valid (valid_o),
        .hi    (s3_hi_unused),
        .md    (median_o),
        .lo    (s3_lo_unused)
    );

`ifdef MEDIAN_MINMAX_OUT_EN
    // Window extremes travel the same S2/S3 timing as the median.
    logic [DW-1:0] s2_max;
    logic [DW-1:0] s2_min;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_max <= '0;
            s2_min <= '0;
            max_o  <= '0;
            min_o  <= '0;
        end else begin
            if (s2_load) begin
                s2_max <= max3(fld(win_next[0], HI), fld(win_next[1], HI), fld(win_next[2], HI));
                s2_min <= min3(fld(win_next[0], LO), fld(win_next[1], LO), fld(win_next[2], LO));
            end
            if (s2_valid) begin
                max_o <= s2_max;
                min_o <= s2_min;
            end
        end
    end
`endif

endmodule : median3x3_pipe
